fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I core. It sits directly upstream of `inst_mem`: it owns the program counter, drives `inst_mem.addr`, and captures the returned `instruction` into the IF/ID pipeline register for the decoder. It supports hazard stalls and branch/jump redirects, squashing the wrong-path instruction on a redirect.

---
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch; owns the PC, drives the instruction
//               memory address and captures the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] inst_addr,
   input  logic [31:0] instruction,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] c_pc_step = 32'd4;

   logic [31:0] r_pc;
   logic        r_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_pc_plus4;
   logic [31:0] r_instr;
   logic [31:0] r_count;
   logic [31:0] w_pc_next_seq;

   assign w_pc_next_seq = r_pc + c_pc_step;

   // Priority: reset > redirect > stall > advance
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_valid       <= 1'b0;
         r_instr       <= NOP_INSTR;
         r_if_pc       <= 32'd0;
         r_if_pc_plus4 <= 32'd0;
         r_count       <= 32'd0;
      end else if (redirect_valid) begin
         // Wrong-path instruction at r_pc is dropped; IF/ID pc fields hold
         r_pc    <= {redirect_target[31:2], 2'b00};
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end else if (!stall) begin
         r_pc          <= w_pc_next_seq;
         r_if_pc       <= r_pc;
         r_if_pc_plus4 <= w_pc_next_seq;
         r_instr       <= instruction;
         r_valid       <= 1'b1;
         r_count       <= r_count + 32'd1;
      end
   end

   assign inst_addr      = r_pc;
   assign if_id_valid    = r_valid;
   assign if_id_pc       = r_if_pc;
   assign if_id_pc_plus4 = r_if_pc_plus4;
   assign if_id_instr    = r_instr;
   assign fetch_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with a behavioural PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] c_nop     = 32'h0000_0013;
   localparam logic [31:0] c_wrap_pc = 32'hFFFF_FFF8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;

   logic [31:0] inst_addr, instruction, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
   logic        if_id_valid;
   logic [31:0] w_inst_addr, w_instruction, w_if_id_pc, w_if_id_pc_plus4, w_if_id_instr, w_fetch_count;
   logic        w_if_id_valid;

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   exp_t        sb_q[$];
   logic [31:0] m_pc, m_ifpc, m_ifpc4, m_cnt;
   logic        m_valid;

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
   endfunction

   assign instruction   = mem_word(inst_addr);
   assign w_instruction = mem_word(w_inst_addr);

   fetch_stage u_dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .inst_addr(inst_addr), .instruction(instruction),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
      .fetch_count(fetch_count)
   );

   fetch_stage #(.RESET_PC(c_wrap_pc)) u_wrap (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .inst_addr(w_inst_addr), .instruction(w_instruction),
      .if_id_valid(w_if_id_valid), .if_id_pc(w_if_id_pc),
      .if_id_pc_plus4(w_if_id_pc_plus4), .if_id_instr(w_if_id_instr),
      .fetch_count(w_fetch_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: apply inputs, let the edge happen, then advance the model
   task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] t);
      reset = r; stall = s; redirect_valid = rv; redirect_target = t;
      @(posedge clk);
      #1;
      if (r) begin
         m_pc = 32'd0; m_valid = 1'b0; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_cnt = 32'd0;
         sb_q.delete();
      end else if (rv) begin
         m_pc = t & ~32'd3;
         m_valid = 1'b0;
      end else if (!s) begin
         m_cnt   = m_cnt + 32'd1;
         sb_q.push_back('{pc: m_pc, instr: mem_word(m_pc), cnt: m_cnt});
         m_ifpc  = m_pc;
         m_ifpc4 = m_pc + 32'd4;
         m_pc    = m_pc + 32'd4;
         m_valid = 1'b1;
      end
   endtask

   // Monitor: per-cycle state checks plus scoreboard pop on each new fetch
   initial begin : p_monitor
      logic [31:0] last_cnt;
      exp_t        e;
      last_cnt = 32'd0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("inst_addr", inst_addr, m_pc);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("fetch_count", fetch_count, m_cnt);
            chk("if_id_pc", if_id_pc, m_ifpc);
            chk("if_id_pc_plus4", if_id_pc_plus4, m_ifpc4);
            if (!if_id_valid)
               chk("bubble_nop", if_id_instr, c_nop);
            if (if_id_valid && fetch_count !== last_cnt) begin
               if (sb_q.size() == 0) begin
                  chk("sb_underflow", 32'(sb_q.size()), 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  chk("sb_pc", if_id_pc, e.pc);
                  chk("sb_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
                  chk("sb_instr", if_id_instr, e.instr);
                  chk("sb_count", fetch_count, e.cnt);
               end
            end
            last_cnt = fetch_count;
         end
      end
   end

   initial begin : p_driver
      logic [31:0] t;
      m_pc = 32'd0; m_valid = 1'b0; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_cnt = 32'd0;

      cyc(1, 0, 0, 0);
      mon_en = 1'b1;
      cyc(1, 0, 0, 0);
      chk("rst_instr", if_id_instr, c_nop);
      chk("wrap_rst_addr", w_inst_addr, c_wrap_pc);

      // Run 0x0 -> 0x8, checking the wrap-around instance alongside
      cyc(0, 0, 0, 0);
      chk("wrap_addr1", w_inst_addr, 32'hFFFF_FFFC);
      chk("wrap_ifpc1", w_if_id_pc, c_wrap_pc);
      cyc(0, 0, 0, 0);
      chk("wrap_addr2", w_inst_addr, 32'h0000_0000);
      chk("wrap_ifpc2", w_if_id_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4_2", w_if_id_pc_plus4, 32'h0000_0000);

      // Stall three cycles at pc 0x8
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
      chk("stall_addr", inst_addr, 32'h8);
      chk("stall_instr", if_id_instr, mem_word(32'h4));
      cyc(0, 0, 0, 0);
      chk("post_stall_instr", if_id_instr, mem_word(32'h8));

      // Redirect at pc 0xC to 0x40
      cyc(0, 0, 1, 32'h40);
      chk("redir_addr", inst_addr, 32'h40);
      cyc(0, 0, 0, 0);
      chk("redir_tgt_instr", if_id_instr, mem_word(32'h40));
      cyc(0, 0, 0, 0);

      // Redirect overriding stall with misaligned target
      cyc(0, 1, 1, 32'h23);
      chk("redir_stall_addr", inst_addr, 32'h20);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

      // Reset mid-run while IF/ID is valid
      cyc(1, 0, 0, 0);
      chk("midrst_addr", inst_addr, 32'h0);
      cyc(0, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         t = $urandom();
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 6) == 0), t);
      end
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
